conv_encoder_tx: RTL
====================

Name: conv_encoder_tx

Overview:
- Sequential rate-1/2, constraint-length-3 convolutional encoder. It is the transmit end of the Viterbi trellis decoder path.
- Accepts a MSG_W-bit message over a valid/ready handshake and encodes it LSB first from the all-zero start state.
- Streams one 2-bit code symbol per cycle under backpressure.
- Also presents the assembled 2*MSG_W-bit codeword in the bit order the decoder consumes.

Parameters:
- MSG_W, 4, message bits per frame (≥2).
- G0, 3'b111, generator for symbol bit 0; bit2 = current input, bit1 = d1, bit0 = d2.
- G1, 3'b101, generator for symbol bit 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- msg  in  MSG_W  message; bit 0 is encoded first.
- msg_valid  in  1  message offered.
- msg_ready  out  1  encoder can accept a message.
- sym_data  out  2  code symbol {c1,c0}.
- sym_valid  out  1  sym_data valid.
- sym_ready  in  1  downstream accepts symbol.
- sym_last  out  1  final symbol of frame.
- code_word  out  2*MSG_W  codeword; code_word[2i+1:2i] = symbol for msg[i].
- code_valid  out  1  one-cycle pulse when code_word updates.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, shift state {d1,d2}=0, bit counter=0, msg_ready=0 during reset, sym_valid=0, sym_data=0, sym_last=0, code_word=0, code_valid=0.
- FSM states: IDLE, ENC, TAIL (TAIL only with the optional feature).
- IDLE:
  - msg_ready=1, sym_valid=0, sym_data forced to 0.
  - On msg_valid&&msg_ready: latch msg, clear {d1,d2} and the counter, go to ENC. The first symbol is valid the next cycle.
- ENC:
  - u = latched msg[cnt].
  - c0 = parity(G0 & {u,d1,d2}); c1 = parity(G1 & {u,d1,d2}).
  - sym_valid=1; sym_data={c1,c0}, combinational from registers.
  - On sym_ready: d2<=d1, d1<=u, cnt++, and code_word[2cnt+1:2cnt] is written into a staging register.
  - If sym_ready is low, all state holds and sym_data stays stable (AXI-style: valid never drops without a handshake).
- Last data symbol (cnt==MSG_W-1) handshake:
  - code_word is loaded from staging plus the final symbol.
  - code_valid pulses the following cycle.
  - Next state is TAIL (if enabled) or IDLE.
- sym_last=1 on the final symbol emitted for the frame.
- Latency: first symbol 1 cycle after message accept. With sym_ready held high, a frame takes MSG_W symbol cycles plus 1 IDLE cycle before the next message accept.
- msg_valid while not in IDLE is ignored (msg_ready=0); the latched message is unaffected.
- code_word holds its value until the next frame completes.
- Reset mid-frame: the frame is abandoned, no code_valid pulse, outputs return to reset values immediately.
- Each frame starts from state 0; without the tail, the end state is not flushed.

Optional Feature:
- Macro CONV_TAIL_FLUSH_EN.
- When defined: after the last data symbol, TAIL emits 2 extra symbols with u=0, returning the state to 00.
  - sym_last moves to the second tail symbol.
  - Tail symbols appear only on the sym_* stream; code_word stays 2*MSG_W bits.
  - code_valid still pulses after the last data symbol handshake.
- When undefined: no TAIL state; sym_last is on data symbol MSG_W-1.

Decomposition:
- Package conv_enc_pkg holds:
  - constants K=3, default G0/G1;
  - FSM state enum {IDLE, ENC, TAIL};
  - function conv_sym(u,d1,d2,g0,g1) returning the 2-bit symbol.
- One natural sub-module: conv_branch_enc, holding the 2-bit shift register, the advance enable and the generator XOR. The top instantiates it and owns the FSM, counter, handshake and codeword assembly.

Test Plan:
- msg=4'b1011, sym_ready=1 → symbols 11,10,10,00; code_word=8'h2B with a code_valid pulse; sym_last on the 4th symbol. With CONV_TAIL_FLUSH_EN, two more symbols 01,11 follow and sym_last is on the last of them.
- msg=4'b0001 → code_word=8'h37; msg=4'b0000 → code_word=8'h00, symbols all 00.
- Backpressure: msg=4'b1011, sym_ready toggled 1,0,0,1,… → sym_data/sym_valid stable during stalls; same symbol sequence and code_word=8'h2B.
- Back-to-back: msg_valid held high with 4'b1011 then 4'b0001 → second frame starts from state 0 (code_word=8'h37, not carried-over state); exactly one IDLE cycle between frames.
- Reset mid-frame: assert rst_n=0 after 2 symbols → sym_valid=0 and no code_valid pulse. code_word is 0 at reset, and the next frame encodes correctly.
- msg_valid pulsed during ENC with a different value → ignored; the in-flight frame output is unchanged.

Source files
------------

// File: rtl/conv_enc_pkg.sv
// Shared constants, FSM state type and symbol function for the rate-1/2, K=3
// convolutional encoder.
package conv_enc_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

  // Generator bit2 taps the current input, bit1 d1, bit0 d2.
  function automatic logic [1:0] conv_sym(input logic u, input logic d1, input logic d2,
                                          input logic [K-1:0] g0, input logic [K-1:0] g1);
    logic [K-1:0] reg_v;
    reg_v = {u, d1, d2};
    return {^(g1 & reg_v), ^(g0 & reg_v)};
  endfunction

endpackage

// File: rtl/conv_branch_enc.sv
// Two-stage encoder shift register {d1,d2} with advance/clear and the
// generator XOR producing the current {c1,c0} symbol.
module conv_branch_enc
  import conv_enc_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  input  logic       u,
  output logic [1:0] sym
);

  logic [1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = 2'b00;
    end else if (adv) begin
      sr_d = {u, sr_q[1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= 2'b00;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sym = conv_sym(u, sr_q[1], sr_q[0], G0, G1);

endmodule

// File: rtl/conv_encoder_tx.sv
// Frame-based convolutional encoder: accepts a message, streams symbols under
// backpressure and assembles the codeword. CONV_TAIL_FLUSH_EN adds a 2-symbol tail.
module conv_encoder_tx
  import conv_enc_pkg::*;
#(
  parameter int           MSG_W = 4,
  parameter logic [K-1:0] G0    = G0_DEF,
  parameter logic [K-1:0] G1    = G1_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MSG_W-1:0]   msg,
  input  logic               msg_valid,
  output logic               msg_ready,
  output logic [1:0]         sym_data,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic               sym_last,
  output logic [2*MSG_W-1:0] code_word,
  output logic               code_valid
);

  localparam int CW = (MSG_W > 1) ? $clog2(MSG_W) : 1;

  enc_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [2*MSG_W-1:0] stage_q, stage_d;
  logic [2*MSG_W-1:0] code_word_q, code_word_d;
  logic               code_valid_q, code_valid_d;

  logic       enc_clr, enc_adv, enc_u, last_data;
  logic [1:0] enc_sym;

  conv_branch_enc #(
    .G0(G0),
    .G1(G1)
  ) u_branch (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (enc_clr),
    .adv  (enc_adv),
    .u    (enc_u),
    .sym  (enc_sym)
  );

  assign last_data = (cnt_q == CW'(MSG_W - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    msg_d        = msg_q;
    stage_d      = stage_q;
    code_word_d  = code_word_q;
    code_valid_d = 1'b0;
    enc_clr      = 1'b0;
    enc_adv      = 1'b0;
    enc_u        = 1'b0;
    sym_valid    = 1'b0;
    sym_last     = 1'b0;

    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          msg_d   = msg;
          cnt_d   = '0;
          stage_d = '0;
          enc_clr = 1'b1;
          state_d = ENC;
        end
      end

      ENC: begin
        sym_valid = 1'b1;
        for (int i = 0; i < MSG_W; i++) begin
          if (cnt_q == CW'(i)) enc_u = msg_q[i];
        end
`ifndef CONV_TAIL_FLUSH_EN
        sym_last = last_data;
`endif
        if (sym_ready) begin
          enc_adv = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          for (int i = 0; i < MSG_W; i++) begin
            if (cnt_q == CW'(i)) stage_d[2*i +: 2] = enc_sym;
          end
          if (last_data) begin
            code_word_d  = stage_d;
            code_valid_d = 1'b1;
`ifdef CONV_TAIL_FLUSH_EN
            cnt_d        = '0;
            state_d      = TAIL;
`else
            state_d      = IDLE;
`endif
          end
        end
      end

`ifdef CONV_TAIL_FLUSH_EN
      // Two zero-input symbols drive the trellis back to state 00.
      TAIL: begin
        sym_valid = 1'b1;
        sym_last  = cnt_q[0];
        if (sym_ready) begin
          enc_adv = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q[0]) state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      msg_q        <= '0;
      stage_q      <= '0;
      code_word_q  <= '0;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      msg_q        <= msg_d;
      stage_q      <= stage_d;
      code_word_q  <= code_word_d;
      code_valid_q <= code_valid_d;
    end
  end

  // Gate with rst_n so the encoder never advertises ready while held in reset.
  assign msg_ready  = (state_q == IDLE) && rst_n;
  assign sym_data   = sym_valid ? enc_sym : 2'b00;
  assign code_word  = code_word_q;
  assign code_valid = code_valid_q;

endmodule
